// File: rtl/iob_pkg.sv
// iob_pkg: shared types, default sizes and the byte-lane merge helper for the IOB posted-write sequencer.
package iob_pkg;
  localparam int IOB_DEPTH = 4;
  localparam int IOB_AW = 23;
  localparam int IOB_DW = 16;

  typedef enum logic [1:0] {IDLE, PW_BUSY, NP_BUSY, NP_DONE} state_t;

  typedef struct packed {
    logic [IOB_AW-1:0] addr;
    logic [IOB_DW-1:0] data;
    logic [1:0]        be;
  } pw_entry_t;

  function automatic pw_entry_t merge_entry(input pw_entry_t o, input pw_entry_t n);
    merge_entry = o;
    merge_entry.data = {n.be[1] ? n.data[IOB_DW-1:IOB_DW/2] : o.data[IOB_DW-1:IOB_DW/2],
                        n.be[0] ? n.data[IOB_DW/2-1:0] : o.data[IOB_DW/2-1:0]};
    merge_entry.be = o.be | n.be;
  endfunction
endpackage

// File: rtl/iob_pw_fifo.sv
// iob_pw_fifo: posted-write FIFO with registered count and ack; same-address merging into
// the newest entry when PW_MERGE_EN is defined.
module iob_pw_fifo
  import iob_pkg::*;
#(
  parameter int DEPTH = IOB_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  pw_entry_t din,
  input  logic      pop,
  input  logic      head_locked,
  output pw_entry_t head,
  output logic      ack,
  output logic      full,
  output logic      empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
`ifdef PW_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  pw_entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr, last;
  logic [CW-1:0] cnt;
  logic merge, accept, wr_en;

  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head  = mem[rd];
  assign last  = wr - PW'(1);
  // with one entry left it is the head, which is either in flight or being launched
  assign merge  = MERGE && push && !empty && mem[last].addr == din.addr &&
                  !(cnt == CW'(1) && head_locked);
  assign accept = push && (merge || !full);
  assign wr_en  = accept && !merge;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      ack <= 1'b0;
    end else begin
      ack <= accept;
      if (wr_en) wr <= wr + PW'(1);
      if (pop) rd <= rd + PW'(1);
      cnt <= cnt + CW'(wr_en) - CW'(pop);
    end

  always_ff @(posedge clk)
    if (wr_en) mem[wr] <= din;
    else if (merge) mem[last] <= merge_entry(mem[last], din);
endmodule

// File: rtl/iob_pw_sequencer.sv
// iob_pw_sequencer: drains posted writes to the motherboard bus, then issues non-posted IOCS accesses.
// AW/DW must match iob_pkg sizes; optional feature macro: PW_MERGE_EN.
module iob_pw_sequencer
  import iob_pkg::*;
#(
  parameter int DEPTH = IOB_DEPTH,
  parameter int AW    = IOB_AW,
  parameter int DW    = IOB_DW
) (
  input  logic          CLK,
  input  logic          nRES,
  input  logic          PWReq,
  input  logic [AW-1:0] PWA,
  input  logic [DW-1:0] PWD,
  input  logic [1:0]    PWBE,
  output logic          PWAck,
  output logic          PWFull,
  input  logic          NPReq,
  input  logic          NPWE,
  input  logic [AW-1:0] NPA,
  input  logic [DW-1:0] NPD,
  input  logic [1:0]    NPBE,
  output logic          NPAck,
  output logic [DW-1:0] NPQ,
  output logic          IOReq,
  output logic          IOWE,
  output logic [AW-1:0] IOA,
  output logic [DW-1:0] IOD,
  output logic [1:0]    IOBE,
  input  logic          IOAck,
  input  logic [DW-1:0] IOQ
);
  state_t    state;
  pw_entry_t din, head;
  logic      empty, pop, head_locked;

  assign din         = {PWA, PWD, PWBE};
  assign pop         = state == PW_BUSY && IOAck;
  assign head_locked = state == IDLE || state == PW_BUSY;

  iob_pw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(CLK), .rst_n(nRES), .push(PWReq), .din(din), .pop(pop), .head_locked(head_locked),
    .head(head), .ack(PWAck), .full(PWFull), .empty(empty)
  );

  always_ff @(posedge CLK or negedge nRES)
    if (!nRES) begin
      state <= IDLE;
      IOReq <= 1'b0;
      IOWE  <= 1'b0;
      IOA   <= '0;
      IOD   <= '0;
      IOBE  <= '0;
      NPAck <= 1'b0;
      NPQ   <= '0;
    end else begin
      NPAck <= 1'b0;
      case (state)
        IDLE:
          if (!empty) begin
            {IOA, IOD, IOBE} <= {head.addr, head.data, head.be};
            IOWE  <= 1'b1;
            IOReq <= 1'b1;
            state <= PW_BUSY;
          end else if (NPReq) begin
            {IOA, IOD, IOBE, IOWE} <= {NPA, NPD, NPBE, NPWE};
            IOReq <= 1'b1;
            state <= NP_BUSY;
          end
        PW_BUSY:
          if (IOAck) begin
            IOReq <= 1'b0;
            state <= IDLE;
          end
        NP_BUSY:
          if (IOAck) begin
            IOReq <= 1'b0;
            if (!IOWE) NPQ <= IOQ;
            NPAck <= 1'b1;
            state <= NP_DONE;
          end
        NP_DONE: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_iob_pw_sequencer.sv
// tb_iob_pw_sequencer: table-driven per-cycle vectors plus hand sequences for reset and merge.
module tb_iob_pw_sequencer;
  logic        CLK = 1'b0;
  logic        nRES;
  logic        PWReq, NPReq, NPWE, IOAck;
  logic [22:0] PWA, NPA;
  logic [15:0] PWD, NPD, IOQ;
  logic [1:0]  PWBE, NPBE;
  logic        PWAck, PWFull, NPAck, IOReq, IOWE;
  logic [15:0] NPQ, IOD;
  logic [22:0] IOA;
  logic [1:0]  IOBE;
  int total = 0, bad = 0;

  iob_pw_sequencer dut (
    .CLK(CLK), .nRES(nRES), .PWReq(PWReq), .PWA(PWA), .PWD(PWD), .PWBE(PWBE),
    .PWAck(PWAck), .PWFull(PWFull), .NPReq(NPReq), .NPWE(NPWE), .NPA(NPA), .NPD(NPD),
    .NPBE(NPBE), .NPAck(NPAck), .NPQ(NPQ), .IOReq(IOReq), .IOWE(IOWE), .IOA(IOA),
    .IOD(IOD), .IOBE(IOBE), .IOAck(IOAck), .IOQ(IOQ)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        pw;
    logic [22:0] a;
    logic [15:0] d;
    logic        ia;
    logic        np;
    logic [15:0] q;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic pw, input logic [22:0] a, input logic [15:0] d, input logic ia,
                     input logic np, input logic [15:0] q, input logic ea, input logic ef,
                     input logic er, input logic ew, input logic [22:0] eioa,
                     input logic [15:0] eiod, input logic enp, input logic [15:0] enq);
    vec_t t;
    t.pw = pw; t.a = a; t.d = d; t.ia = ia; t.np = np; t.q = q;
    t.exp = {4'b0, ea, ef, er, ew, eioa, eiod, enp, enq};
    tbl.push_back(t);
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask

  task automatic drv(input logic pw, input logic [22:0] a, input logic [15:0] d,
                     input logic [1:0] be, input logic ia);
    PWReq = pw; PWA = a; PWD = d; PWBE = be; IOAck = ia;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    nRES = 1'b0; PWReq = 0; PWA = '0; PWD = '0; PWBE = 2'b11; IOAck = 0; IOQ = '0;
    NPReq = 0; NPWE = 0; NPA = 23'h700000; NPD = 16'h5555; NPBE = 2'b11;
    // single posted write, IOAck 3 clocks after IOReq rises
    add(1, 23'h1F8000, 16'hA5A5, 0, 0, 0,  1, 0, 0, 0, 23'h0,      16'h0,    0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h1F8000, 16'hA5A5, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h1F8000, 16'hA5A5, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h1F8000, 16'hA5A5, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h1F8000, 16'hA5A5, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 23'h1F8000, 16'hA5A5, 0, 0);
    // five pushes, fifth dropped when full, then in-order drain
    add(1, 23'h100, 16'h1000, 0, 0, 0,     1, 0, 0, 1, 23'h1F8000, 16'hA5A5, 0, 0);
    add(1, 23'h101, 16'h1001, 0, 0, 0,     1, 0, 1, 1, 23'h100, 16'h1000, 0, 0);
    add(1, 23'h102, 16'h1002, 0, 0, 0,     1, 0, 1, 1, 23'h100, 16'h1000, 0, 0);
    add(1, 23'h103, 16'h1003, 0, 0, 0,     1, 1, 1, 1, 23'h100, 16'h1000, 0, 0);
    add(1, 23'h104, 16'h1004, 0, 0, 0,     0, 1, 1, 1, 23'h100, 16'h1000, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 1, 1, 1, 23'h100, 16'h1000, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h100, 16'h1000, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h101, 16'h1001, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h101, 16'h1001, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h102, 16'h1002, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h102, 16'h1002, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h103, 16'h1003, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h103, 16'h1003, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 23'h103, 16'h1003, 0, 0);
    // push and pop in one cycle at count 2, pointers wrap
    add(1, 23'h200, 16'h2000, 0, 0, 0,     1, 0, 0, 1, 23'h103, 16'h1003, 0, 0);
    add(1, 23'h201, 16'h2001, 0, 0, 0,     1, 0, 1, 1, 23'h200, 16'h2000, 0, 0);
    add(1, 23'h202, 16'h2002, 1, 0, 0,     1, 0, 0, 1, 23'h200, 16'h2000, 0, 0);
    add(1, 23'h203, 16'h2003, 0, 0, 0,     1, 0, 1, 1, 23'h201, 16'h2001, 0, 0);
    add(1, 23'h204, 16'h2004, 0, 0, 0,     1, 1, 1, 1, 23'h201, 16'h2001, 0, 0);
    add(1, 23'h205, 16'h2005, 0, 0, 0,     0, 1, 1, 1, 23'h201, 16'h2001, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h201, 16'h2001, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h202, 16'h2002, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h202, 16'h2002, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h203, 16'h2003, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h203, 16'h2003, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 1, 1, 23'h204, 16'h2004, 0, 0);
    add(0, 0, 0, 1, 0, 0,                  0, 0, 0, 1, 23'h204, 16'h2004, 0, 0);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 1, 23'h204, 16'h2004, 0, 0);
    // queued writes ahead of a non-posted read; no re-issue through NP_DONE
    add(1, 23'h300, 16'h3000, 0, 0, 0,     1, 0, 0, 1, 23'h204, 16'h2004, 0, 0);
    add(1, 23'h301, 16'h3001, 0, 1, 0,     1, 0, 1, 1, 23'h300, 16'h3000, 0, 0);
    add(0, 0, 0, 1, 1, 0,                  0, 0, 0, 1, 23'h300, 16'h3000, 0, 0);
    add(0, 0, 0, 0, 1, 0,                  0, 0, 1, 1, 23'h301, 16'h3001, 0, 0);
    add(0, 0, 0, 1, 1, 0,                  0, 0, 0, 1, 23'h301, 16'h3001, 0, 0);
    add(0, 0, 0, 0, 1, 0,                  0, 0, 1, 0, 23'h700000, 16'h5555, 0, 0);
    add(0, 0, 0, 1, 1, 16'h1234,           0, 0, 0, 0, 23'h700000, 16'h5555, 1, 16'h1234);
    add(0, 0, 0, 0, 1, 0,                  0, 0, 0, 0, 23'h700000, 16'h5555, 0, 16'h1234);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 23'h700000, 16'h5555, 0, 16'h1234);
    add(0, 0, 0, 0, 0, 0,                  0, 0, 0, 0, 23'h700000, 16'h5555, 0, 16'h1234);

    repeat (2) @(negedge CLK);
    chk("reset_state", 64'({IOReq, PWAck, NPAck, PWFull, IOWE, IOA, IOD, IOBE, NPQ}), 64'h0);
    nRES = 1'b1;
    foreach (tbl[i]) begin
      PWReq = tbl[i].pw; PWA = tbl[i].a; PWD = tbl[i].d; IOAck = tbl[i].ia;
      NPReq = tbl[i].np; IOQ = tbl[i].q;
      @(negedge CLK);
      chk($sformatf("row%0d", i),
          64'({PWAck, PWFull, IOReq, IOWE, IOA, IOD, NPAck, NPQ}), tbl[i].exp);
    end
    NPReq = 0; IOQ = '0;

    // asynchronous reset mid-cycle while a posted write is in flight
    drv(1, 23'h400, 16'h4000, 2'b11, 0);
    drv(0, 0, 0, 2'b11, 0);
    chk("rst_inflight", 64'({IOReq, IOA}), 64'({1'b1, 23'h400}));
    #2 nRES = 1'b0;
    #1 chk("rst_async", 64'({IOReq, PWAck, NPAck, PWFull, IOWE, IOA, IOD, IOBE, NPQ}), 64'h0);
    @(negedge CLK);
    nRES = 1'b1;
    drv(0, 0, 0, 2'b11, 1);
    chk("rst_ioack_ignored", 64'({IOReq, NPAck, PWAck}), 64'h0);
    drv(0, 0, 0, 2'b11, 0);
    chk("rst_fifo_empty", 64'({IOReq, PWFull}), 64'h0);

    // same-address writes behind an older entry in flight
    drv(1, 23'h500, 16'h5000, 2'b11, 0);
    drv(1, 23'h1F8000, 16'hAB00, 2'b10, 0);
    chk("mrg_ack1", 64'({PWAck, IOReq, IOA}), 64'({1'b1, 1'b1, 23'h500}));
    drv(1, 23'h1F8000, 16'h00CD, 2'b01, 0);
    chk("mrg_ack2", 64'({PWAck, IOReq, IOA}), 64'({1'b1, 1'b1, 23'h500}));
    drv(0, 0, 0, 2'b11, 1);
    drv(0, 0, 0, 2'b11, 0);
`ifdef PW_MERGE_EN
    chk("mrg_entry", 64'({IOReq, IOA, IOD, IOBE}), 64'({1'b1, 23'h1F8000, 16'hABCD, 2'b11}));
    drv(0, 0, 0, 2'b11, 1);
    drv(0, 0, 0, 2'b11, 0);
    chk("mrg_single", 64'({IOReq, PWFull}), 64'h0);
`else
    chk("nomrg_first", 64'({IOReq, IOA, IOD, IOBE}), 64'({1'b1, 23'h1F8000, 16'hAB00, 2'b10}));
    drv(0, 0, 0, 2'b11, 1);
    drv(0, 0, 0, 2'b11, 0);
    chk("nomrg_second", 64'({IOReq, IOA, IOD, IOBE}), 64'({1'b1, 23'h1F8000, 16'h00CD, 2'b01}));
    drv(0, 0, 0, 2'b11, 1);
    drv(0, 0, 0, 2'b11, 0);
    chk("nomrg_drained", 64'({IOReq, PWFull}), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
